// File: rtl/batch_mul_engine.sv
// batch_mul_engine: reads operand pairs from byte memory, multiplies them with a shift-add datapath and writes the products back.
module batch_mul_engine #(
    parameter int OP_BYTES  = 2,
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sgn,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);
    localparam int W  = 8 * OP_BYTES;
    localparam int CW = $clog2(W) + 1;
    localparam int PW = $clog2(NUM_PAIRS) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MUL, STORE, DONE} state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic            sgn_q, sgn_d;
    logic [PW-1:0]   pair_q, pair_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  m_q, m_d;
    logic [2*W-1:0]  acc_q, acc_d;

    // state and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            sgn_q   <= 1'b0;
            pair_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            sgn_q   <= sgn_d;
            pair_q  <= pair_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
        end
    end

    // next-state, datapath steps and memory interface; the multiplier MSB carries negative weight in signed mode
    always_comb begin
        state_d     = state_q;
        start_d     = start;
        sgn_d       = sgn_q;
        pair_d      = pair_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        acc_d       = acc_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        done        = state_q == DONE;
        busy        = state_q inside {LOAD_A, LOAD_B, MUL, STORE};
        case (state_q)
            IDLE: begin
                if (start_q && !start) begin
                    sgn_d   = sgn;
                    pair_d  = '0;
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                mem_addr = ADDR_W'(SRC_BASE + OP_BYTES * (2 * int'(pair_q) + 1) + int'(cnt_q));
                a_d      = W'({a_q, mem_rd_data});
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(OP_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                mem_addr = ADDR_W'(SRC_BASE + OP_BYTES * 2 * int'(pair_q) + int'(cnt_q));
                b_d      = W'({b_q, mem_rd_data});
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(OP_BYTES - 1)) begin
                    cnt_d   = '0;
                    m_d     = {{W{sgn_q & a_q[W-1]}}, a_q};
                    acc_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = !b_q[0] ? acc_q :
                        (sgn_q && cnt_q == CW'(W - 1)) ? acc_q - m_q : acc_q + m_q;
                m_d   = m_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = STORE;
                end
            end
            STORE: begin
                mem_addr    = ADDR_W'(DST_BASE + 2 * OP_BYTES * int'(pair_q) + int'(cnt_q));
                mem_wr_en   = 1'b1;
                mem_wr_data = acc_q[2*W-1 -: 8];
                acc_d       = acc_q << 8;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(2 * OP_BYTES - 1)) begin
                    cnt_d   = '0;
                    pair_d  = pair_q + PW'(1);
                    state_d = (pair_q == PW'(NUM_PAIRS - 1)) ? DONE : LOAD_A;
                end
            end
            DONE: begin
                if (start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start && busy) state_d = IDLE;
    end
endmodule

// File: tb/tb_batch_mul_engine.sv
// tb_batch_mul_engine: table vectors, randomized runs against an arithmetic model, abort/reset sequences and a wide-operand instance.
module tb_batch_mul_engine;
    logic       clk = 1'b0;
    logic       rst_n, start, sgn, start2, sgn2;
    logic       done, busy, wr_en, done2, busy2, wr_en2;
    logic [7:0] addr, rd, wdata, addr2, rd2, wdata2;
    logic [7:0] mem [256];
    logic [7:0] mem2[256];
    int         pass_cnt = 0, total_cnt = 0;
    int         wr_cnt, low_wr, wr_cnt2;
    int         edges, busy_bad, seen, bad;
    logic [31:0] expv[16];

    typedef struct {
        bit          s;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    assign rd  = mem[addr];
    assign rd2 = mem2[addr2];

    batch_mul_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .done(done), .busy(busy),
        .mem_addr(addr), .mem_rd_data(rd), .mem_wr_en(wr_en), .mem_wr_data(wdata)
    );

    batch_mul_engine #(.OP_BYTES(4), .NUM_PAIRS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sgn(sgn2), .done(done2), .busy(busy2),
        .mem_addr(addr2), .mem_rd_data(rd2), .mem_wr_en(wr_en2), .mem_wr_data(wdata2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        if (wr_en) begin
            mem[addr] = wdata;
            wr_cnt++;
            if (addr < 8'd64) low_wr++;
        end
        if (wr_en2) begin
            mem2[addr2] = wdata2;
            wr_cnt2++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mul(input bit s, input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[31:0];
    endfunction

    function automatic logic [15:0] op(input int i);
        return {mem[2*i], mem[2*i+1]};
    endfunction

    function automatic logic [31:0] prod(input int j);
        return {mem[64+4*j], mem[65+4*j], mem[66+4*j], mem[67+4*j]};
    endfunction

    task automatic fill(input bit s);
        for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? 8'($urandom) : 8'hA5;
        for (int j = 0; j < 16; j++) expv[j] = ref_mul(s, op(2*j+1), op(2*j));
    endtask

    task automatic run(input bit which, input bit s, output int n, output int bb);
        wr_cnt = 0; low_wr = 0; wr_cnt2 = 0;
        if (which) begin sgn2 = s; start2 = 1'b1; end
        else begin sgn = s; start = 1'b1; end
        step();
        step();
        if (which) start2 = 1'b0; else start = 1'b0;
        step();
        if (which) sgn2 = ~s; else sgn = ~s;
        n = 0; bb = 0;
        while (n < 1000) begin
            if (!(which ? busy2 : busy)) bb++;
            step();
            n++;
            if (which ? done2 : done) break;
        end
    endtask

    task automatic release_start(input bit which, input string name);
        if (which) start2 = 1'b1; else start = 1'b1;
        step();
        check({name, " done falls"}, which ? done2 : done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; sgn = 1'b0; start2 = 1'b1; sgn2 = 1'b0;
        wr_cnt = 0; low_wr = 0; wr_cnt2 = 0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; mem2[i] = 8'h00; end
        #12;
        check("reset done", done, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset wr_en", wr_en, 1'b0);
        check("reset addr", addr, 8'h00);
        check("reset wdata", wdata, 8'h00);
        check("reset done2", {done2, busy2, wr_en2}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        step();

        vecs[0] = '{1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA};
        vecs[1] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[3] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[5] = '{1'b0, 16'h8000, 16'h0002, 32'h00010000};
        vecs[6] = '{1'b1, 16'h1234, 16'h0000, 32'h00000000};
        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].s);
            {mem[0], mem[1]} = vecs[v].b;
            {mem[2], mem[3]} = vecs[v].a;
            run(0, vecs[v].s, edges, busy_bad);
            check($sformatf("vec%0d done edge", v), edges, 384);
            check($sformatf("vec%0d busy", v), busy_bad, 0);
            check($sformatf("vec%0d product", v), prod(0), vecs[v].p);
            check($sformatf("vec%0d strobes", v), wr_cnt, 64);
            release_start(0, $sformatf("vec%0d", v));
        end

        for (int sd = 0; sd < 10; sd++) begin
            fill(sd < 8);
            run(0, sd < 8, edges, busy_bad);
            check($sformatf("rnd%0d done edge", sd), edges, 384);
            check($sformatf("rnd%0d busy", sd), busy_bad, 0);
            for (int j = 0; j < 16; j++) check($sformatf("rnd%0d prod%0d", sd, j), prod(j), expv[j]);
            check($sformatf("rnd%0d strobes", sd), wr_cnt, 64);
            check($sformatf("rnd%0d low writes", sd), low_wr, 0);
            release_start(0, $sformatf("rnd%0d", sd));
        end

        fill(1'b1);
        wr_cnt = 0; low_wr = 0;
        sgn = 1'b1; start = 1'b1;
        step();
        step();
        start = 1'b0;
        step();
        repeat (100) step();
        start = 1'b1;
        step();
        check("abort busy", busy, 1'b0);
        seen = 0;
        repeat (400) begin step(); if (done) seen++; end
        check("abort done never", seen, 0);
        for (int j = 0; j < 4; j++) check($sformatf("abort prod%0d", j), prod(j), expv[j]);
        bad = 0;
        for (int i = 80; i < 256; i++) if (mem[i] !== 8'hA5) bad++;
        check("abort nothing beyond", bad, 0);
        check("abort strobes", wr_cnt, 16);
        for (int i = 64; i < 256; i++) mem[i] = 8'hA5;
        run(0, 1'b1, edges, busy_bad);
        check("relaunch done edge", edges, 384);
        for (int j = 0; j < 16; j++) check($sformatf("relaunch prod%0d", j), prod(j), expv[j]);
        release_start(0, "relaunch");

        fill(1'b1);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        step();
        repeat (10) step();
        check("pre-reset busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {done, busy, wr_en, addr, wdata}, 19'h0);
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin step(); if (busy || done) seen++; end
        check("held low no launch", seen, 0);
        run(0, 1'b1, edges, busy_bad);
        check("post-reset done edge", edges, 384);
        for (int j = 0; j < 16; j++) check($sformatf("post-reset prod%0d", j), prod(j), expv[j]);
        release_start(0, "post-reset");

        for (int i = 0; i < 256; i++) mem2[i] = 8'hA5;
        {mem2[0], mem2[1], mem2[2], mem2[3]}     = 32'h80000000;
        {mem2[4], mem2[5], mem2[6], mem2[7]}     = 32'hFFFFFFFF;
        {mem2[8], mem2[9], mem2[10], mem2[11]}   = 32'hFFFFFFFF;
        {mem2[12], mem2[13], mem2[14], mem2[15]} = 32'h00000003;
        run(1, 1'b1, edges, busy_bad);
        check("wide done edge", edges, 96);
        check("wide busy", busy_bad, 0);
        check("wide prod0", {mem2[64], mem2[65], mem2[66], mem2[67], mem2[68], mem2[69], mem2[70], mem2[71]},
              64'h0000000080000000);
        check("wide prod1", {mem2[72], mem2[73], mem2[74], mem2[75], mem2[76], mem2[77], mem2[78], mem2[79]},
              64'hFFFFFFFFFFFFFFFD);
        check("wide strobes", wr_cnt2, 16);
        release_start(1, "wide");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
